// File: rtl/storage_req_adapter.sv
// storage_req_adapter: in-order request FIFO between the core data port and storage_controller.
// Optional external-read timeout with sticky fault is built when STORAGE_REQ_TIMEOUT_EN is defined.
module storage_req_adapter #(
  parameter int          MEM_W          = 32,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [31:0] SRAM_LIMIT     = 32'h0000_2000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req_i,
  output logic               mem_gnt_o,
  input  logic [31:0]        mem_addr_i,
  input  logic               mem_we_i,
  input  logic [MEM_W/8-1:0] mem_be_i,
  input  logic [MEM_W-1:0]   mem_wdata_i,
  output logic               mem_rvalid_o,
  output logic [MEM_W-1:0]   mem_rdata_o,
  output logic               mem_err_o,
  input  logic               prog_mode_i,
  output logic               fault_o,
  output logic               sc_memory_access,
  output logic               sc_is_writing,
  output logic [31:0]        sc_addr,
  output logic [MEM_W-1:0]   sc_d_in,
  output logic [MEM_W/8-1:0] sc_be,
  input  logic [MEM_W-1:0]   sc_d_out,
  input  logic               sc_out_valid
);
  localparam int BE_W  = MEM_W / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0]      addr;
    logic             we;
    logic [BE_W-1:0]  be;
    logic [MEM_W-1:0] wdata;
  } req_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP} state_t;

  function automatic logic is_ext(input logic [31:0] a);
    return a >= SRAM_LIMIT;
  endfunction

  req_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           fifo_full, fifo_empty, push, pop, drain;
  req_t           head, inflight;
  state_t         state;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign mem_gnt_o  = mem_req_i & ~fifo_full & ~prog_mode_i & ~fault_o;
  assign push       = mem_gnt_o;
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
  // While draining, RESP pops the next entry itself so error responses come out every cycle.
  assign drain      = prog_mode_i | fault_o;
  assign pop        = ~fifo_empty & ((state == IDLE) | ((state == RESP) & drain));

  // NOTE: the storage array carries no reset; the pointers alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= '{mem_addr_i, mem_we_i, mem_be_i, mem_wdata_i};
  end

  // NOTE: sequential state uses non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign sc_is_writing = inflight.we;
  assign sc_addr       = inflight.addr;
  assign sc_d_in       = inflight.wdata;
  assign sc_be         = inflight.be;

`ifdef STORAGE_REQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             fault_q;
  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      inflight         <= '0;
      sc_memory_access <= 1'b0;
      mem_rvalid_o     <= 1'b0;
      mem_rdata_o      <= '0;
      mem_err_o        <= 1'b0;
`ifdef STORAGE_REQ_TIMEOUT_EN
      tmo_cnt          <= '0;
      fault_q          <= 1'b0;
`endif
    end else begin
      // Pulses default low each cycle; the response is loaded on the way into RESP.
      sc_memory_access <= 1'b0;
      mem_rvalid_o     <= 1'b0;
      mem_rdata_o      <= '0;
      mem_err_o        <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            inflight <= head;
            if (drain) begin
              mem_rvalid_o <= 1'b1;
              mem_err_o    <= 1'b1;
              state        <= RESP;
            end else if (head.we && is_ext(head.addr)) begin
              // External writes are refused; they share the fixed WAIT_WR cycle without touching sc_*.
              state <= WAIT_WR;
            end else begin
              sc_memory_access <= 1'b1;
              state            <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (drain) begin
            mem_rvalid_o <= 1'b1;
            mem_err_o    <= 1'b1;
            state        <= RESP;
          end else begin
            state <= inflight.we ? WAIT_WR : WAIT_RD;
          end
`ifdef STORAGE_REQ_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        WAIT_RD: begin
          if (drain) begin
            mem_rvalid_o <= 1'b1;
            mem_err_o    <= 1'b1;
            state        <= RESP;
          end else if (sc_out_valid) begin
            mem_rvalid_o <= 1'b1;
            mem_rdata_o  <= sc_d_out;
            state        <= RESP;
          end
`ifdef STORAGE_REQ_TIMEOUT_EN
          else if (is_ext(inflight.addr)) begin
            if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
              mem_rvalid_o <= 1'b1;
              mem_err_o    <= 1'b1;
              fault_q      <= 1'b1;
              state        <= RESP;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
`endif
        end
        WAIT_WR: begin
          mem_rvalid_o <= 1'b1;
          mem_err_o    <= is_ext(inflight.addr) | drain;
          state        <= RESP;
        end
        RESP: begin
          if (drain && !fifo_empty) begin
            inflight     <= head;
            mem_rvalid_o <= 1'b1;
            mem_err_o    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_storage_req_adapter.sv
// Directed bench for storage_req_adapter with a behavioural storage_controller (SRAM reads valid
// one cycle after the pulse, external reads never answer).
module tb_storage_req_adapter;
  localparam logic [31:0] LIMIT = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_i = 1'b0, mem_we_i = 1'b0, prog_mode_i = 1'b0;
  logic [31:0] mem_addr_i = '0, mem_wdata_i = '0;
  logic [3:0]  mem_be_i = '0;
  logic        mem_gnt_o, mem_rvalid_o, mem_err_o, fault_o;
  logic [31:0] mem_rdata_o;
  logic        sc_memory_access, sc_is_writing, sc_out_valid;
  logic [31:0] sc_addr, sc_d_in, sc_d_out;
  logic [3:0]  sc_be;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  storage_req_adapter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_addr_i(mem_addr_i),
    .mem_we_i(mem_we_i), .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
    .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
    .prog_mode_i(prog_mode_i), .fault_o(fault_o),
    .sc_memory_access(sc_memory_access), .sc_is_writing(sc_is_writing),
    .sc_addr(sc_addr), .sc_d_in(sc_d_in), .sc_be(sc_be),
    .sc_d_out(sc_d_out), .sc_out_valid(sc_out_valid)
  );

  // storage_controller stand-in: word-addressed SRAM preloaded with 0xC000_0000 | word index
  logic [31:0] sram [2048];
  logic        rd_pend;
  logic [31:0] rd_data;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_data <= '0;
      for (int i = 0; i < 2048; i++) sram[i] <= 32'hC000_0000 | i;
    end else begin
      rd_pend <= sc_memory_access && !sc_is_writing && (sc_addr < LIMIT);
      if (sc_memory_access && !sc_is_writing) rd_data <= sram[sc_addr[12:2]];
      if (sc_memory_access && sc_is_writing && (sc_addr < LIMIT))
        for (int b = 0; b < 4; b++)
          if (sc_be[b]) sram[sc_addr[12:2]][8*b +: 8] <= sc_d_in[8*b +: 8];
    end
  end
  assign sc_out_valid = rd_pend;
  assign sc_d_out     = rd_data;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        rsp_q [$];
  int          gnt_q [$];
  int          iss_q [$];
  logic        iss_we [$];
  logic [3:0]  iss_be [$];
  logic [31:0] iss_addr [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rvalid_o) rsp_q.push_back('{cyc, mem_rdata_o, mem_err_o});
      if (mem_gnt_o) gnt_q.push_back(cyc);
      if (sc_memory_access) begin
        iss_q.push_back(cyc);
        iss_we.push_back(sc_is_writing);
        iss_be.push_back(sc_be);
        iss_addr.push_back(sc_addr);
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic w, input logic [3:0] b,
                      input logic [31:0] d);
    int k = 0;
    mem_req_i = 1'b1; mem_addr_i = a; mem_we_i = w; mem_be_i = b; mem_wdata_i = d;
    #1;
    while (!mem_gnt_o && k < 50) begin
      step(1);
      k++;
    end
    if (!mem_gnt_o) check("gnt_wait_expired", 0, 1);
    step(1);
    mem_req_i = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k = 0;
    while (rsp_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    step(3);
  endtask

  int rb, gb, ib;

  initial begin
    // reset state
    #1;
    check("rst_gnt", mem_gnt_o, 0);
    check("rst_rvalid", mem_rvalid_o, 0);
    check("rst_sc_access", sc_memory_access, 0);
    check("rst_sc_addr", sc_addr, 0);
    check("rst_fault", fault_o, 0);
    step(2);
    rst = 1'b0;
    step(2);

    // write 0x100 then read it back
    rb = rsp_q.size(); gb = gnt_q.size(); ib = iss_q.size();
    send(32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF);
    wait_rsp(rb + 1, 40);
    check("wr100_rsp_count", rsp_q.size(), rb + 1);
    check("wr100_latency", rsp_q[rb].cyc - gnt_q[gb], 4);
    check("wr100_rdata", rsp_q[rb].rdata, 0);
    rb = rsp_q.size(); gb = gnt_q.size(); ib = iss_q.size();
    send(32'h100, 1'b0, 4'hF, 32'h0);
    wait_rsp(rb + 1, 40);
    check("rd100_rsp_count", rsp_q.size(), rb + 1);
    check("rd100_latency", rsp_q[rb].cyc - gnt_q[gb], 4);
    check("rd100_issue_at", iss_q[ib] - gnt_q[gb], 2);
    check("rd100_rdata", rsp_q[rb].rdata, 32'hDEAD_BEEF);
    check("rd100_err", rsp_q[rb].err, 0);

    // partial write at the last SRAM word
    rb = rsp_q.size(); gb = gnt_q.size(); ib = iss_q.size();
    send(32'h1FFC, 1'b1, 4'b0011, 32'h0000_1234);
    wait_rsp(rb + 1, 40);
    check("wr1ffc_issues", iss_q.size(), ib + 1);
    check("wr1ffc_is_writing", iss_we[ib], 1);
    check("wr1ffc_be", iss_be[ib], 4'b0011);
    check("wr1ffc_addr", iss_addr[ib], 32'h1FFC);
    check("wr1ffc_latency", rsp_q[rb].cyc - gnt_q[gb], 4);
    check("wr1ffc_rdata", rsp_q[rb].rdata, 0);
    check("wr1ffc_err", rsp_q[rb].err, 0);
    rb = rsp_q.size();
    send(32'h1FFC, 1'b0, 4'hF, 32'h0);
    wait_rsp(rb + 1, 40);
    check("rd1ffc_rdata", rsp_q[rb].rdata, 32'hC000_1234);

    // six back-to-back reads: FIFO fills, sixth waits one cycle for space
    rb = rsp_q.size(); gb = gnt_q.size(); ib = iss_q.size();
    for (int i = 0; i < 6; i++) send(32'h200 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
    wait_rsp(rb + 6, 80);
    check("burst_rsp_count", rsp_q.size(), rb + 6);
    check("burst_gnt5_at", gnt_q[gb + 4] - gnt_q[gb], 4);
    check("burst_gnt6_held", gnt_q[gb + 5] - gnt_q[gb], 6);
    check("burst_first_rsp", rsp_q[rb].cyc - gnt_q[gb], 4);
    for (int i = 0; i < 6; i++)
      check($sformatf("burst_rdata%0d", i), rsp_q[rb + i].rdata, 32'hC000_0080 + 32'(i));
    for (int i = 1; i < 6; i++)
      check($sformatf("burst_spacing%0d", i), (iss_q[ib + i] - iss_q[ib + i - 1]) >= 3, 1);

    // write to first external address: refused, no controller access
    rb = rsp_q.size(); gb = gnt_q.size(); ib = iss_q.size();
    send(LIMIT, 1'b1, 4'hF, 32'h5555_AAAA);
    wait_rsp(rb + 1, 40);
    check("extwr_issues", iss_q.size(), ib);
    check("extwr_latency", rsp_q[rb].cyc - gnt_q[gb], 3);
    check("extwr_err", rsp_q[rb].err, 1);
    check("extwr_rdata", rsp_q[rb].rdata, 0);

    // hung external reads drained by programming mode, then reset mid-drain
    rb = rsp_q.size(); gb = gnt_q.size(); ib = iss_q.size();
    send(32'h4000, 1'b0, 4'hF, 32'h0);
    send(32'h4004, 1'b0, 4'hF, 32'h0);
    send(32'h4008, 1'b0, 4'hF, 32'h0);
    step(1);
    prog_mode_i = 1'b1;
    mem_req_i = 1'b1; mem_addr_i = 32'h100; mem_we_i = 1'b0;
    #1;
    check("prog_gnt", mem_gnt_o, 0);
    mem_req_i = 1'b0;
    step(2);
    #5;
    rst = 1'b1;
    #1;
    check("rst_async_outputs",
          {mem_gnt_o, mem_rvalid_o, mem_rdata_o, mem_err_o, fault_o, sc_memory_access,
           sc_is_writing, sc_addr, sc_d_in, sc_be}, 0);
    @(posedge clk); #1;
    check("rst_edge_outputs",
          {mem_rvalid_o, mem_err_o, sc_memory_access, sc_addr, sc_be}, 0);
    rst = 1'b0; prog_mode_i = 1'b0;
    step(6);
    check("prog_rsp_count", rsp_q.size(), rb + 2);
    check("prog_rsp0_at", rsp_q[rb].cyc - gnt_q[gb], 5);
    check("prog_rsp1_at", rsp_q[rb + 1].cyc - gnt_q[gb], 6);
    check("prog_rsp_err", {rsp_q[rb].err, rsp_q[rb + 1].err}, 2'b11);
    check("prog_rsp_rdata", {rsp_q[rb].rdata, rsp_q[rb + 1].rdata}, 0);
    check("prog_issues", iss_q.size(), ib + 1);

`ifdef STORAGE_REQ_TIMEOUT_EN
    // external read that never answers times out and sets the sticky fault
    rb = rsp_q.size(); gb = gnt_q.size();
    send(32'h4000, 1'b0, 4'hF, 32'h0);
    wait_rsp(rb + 1, 60);
    check("tmo_rsp_count", rsp_q.size(), rb + 1);
    check("tmo_latency", rsp_q[rb].cyc - gnt_q[gb], 19);
    check("tmo_err", rsp_q[rb].err, 1);
    check("tmo_fault", fault_o, 1);
    mem_req_i = 1'b1; mem_addr_i = 32'h100;
    #1;
    check("tmo_gnt_blocked", mem_gnt_o, 0);
    mem_req_i = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
